// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the unified-memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DM} owner_e;

    localparam int WORD_W = 32;
    localparam int BE_W   = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundles the IF requester, DM requester and memory-side signals of the arbiter.
//
// Handshake: a requester raises req with stable fields; the access happens in
// the cycle where gnt is high (gnt is combinational, same-cycle). Read data is
// returned exactly one cycle later with rvalid; there is no ready/backpressure
// on the response path, and writes never return a response.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 16
);
    import mem_arb_pkg::*;

    logic                if_req;
    logic [ADDR_W-1:0]   if_addr;
    logic                if_gnt;
    logic                if_rvalid;
    logic [WORD_W-1:0]   if_rdata;

    logic                dm_req;
    logic                dm_we;
    logic [BE_W-1:0]     dm_be;
    logic [ADDR_W-1:0]   dm_addr;
    logic [WORD_W-1:0]   dm_wdata;
    logic                dm_gnt;
    logic                dm_rvalid;
    logic [WORD_W-1:0]   dm_rdata;

    logic                mem_en;
    logic [BE_W-1:0]     mem_we;
    logic [ADDR_W-3:0]   mem_addr;
    logic [WORD_W-1:0]   mem_wdata;
    logic [WORD_W-1:0]   mem_rdata;

    logic [15:0]         conflict_cnt;
    owner_e              dbg_rd_owner;
    logic [3:0]          dbg_starve_cnt;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  dm_req, dm_we, dm_be, dm_addr, dm_wdata,
        output dm_gnt, dm_rvalid, dm_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output conflict_cnt, dbg_rd_owner, dbg_starve_cnt
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output dm_req, dm_we, dm_be, dm_addr, dm_wdata,
        input  dm_gnt, dm_rvalid, dm_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  conflict_cnt, dbg_rd_owner, dbg_starve_cnt
    );

endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port unified memory arbiter: DM has priority, IF is protected from
// starvation, and read data is routed to whoever owned the previous access.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int MAX_STARVE = 4
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);

    localparam logic [3:0] STARVE_MAX = 4'(MAX_STARVE);

    logic [3:0]  starve_cnt_q, starve_cnt_d;
    owner_e      rd_owner_q,   rd_owner_d;
    logic [15:0] conflict_cnt_q, conflict_cnt_d;

    logic both_req;
    logic if_gnt;
    logic dm_gnt;
    logic if_rvalid;
    logic dm_rvalid;

    // Byte offset bits are ignored; misaligned addresses simply alias.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{bus.if_addr[1:0], bus.dm_addr[1:0]};

    assign both_req = bus.if_req && bus.dm_req;

    always_comb begin
        if_gnt = 1'b0;
        dm_gnt = 1'b0;
        if (!rst) begin
            if (both_req) begin
                if (starve_cnt_q == STARVE_MAX) begin
                    if_gnt = 1'b1;
                end else begin
                    dm_gnt = 1'b1;
                end
            end else if (bus.if_req) begin
                if_gnt = 1'b1;
            end else if (bus.dm_req) begin
                dm_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        starve_cnt_d = 4'd0;
        if (bus.if_req && !if_gnt) begin
            starve_cnt_d = (starve_cnt_q == STARVE_MAX) ? starve_cnt_q : starve_cnt_q + 4'd1;
        end

        rd_owner_d = OWN_NONE;
        if (if_gnt) begin
            rd_owner_d = OWN_IF;
        end else if (dm_gnt && !bus.dm_we) begin
            rd_owner_d = OWN_DM;
        end

        conflict_cnt_d = conflict_cnt_q;
        if (both_req && (conflict_cnt_q != 16'hFFFF)) begin
            conflict_cnt_d = conflict_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_q   <= 4'd0;
            rd_owner_q     <= OWN_NONE;
            conflict_cnt_q <= 16'd0;
        end else begin
            starve_cnt_q   <= starve_cnt_d;
            rd_owner_q     <= rd_owner_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign bus.if_gnt    = if_gnt;
    assign bus.dm_gnt    = dm_gnt;
    assign bus.mem_en    = if_gnt || dm_gnt;
    assign bus.mem_addr  = if_gnt ? bus.if_addr[ADDR_W-1:2] :
                           dm_gnt ? bus.dm_addr[ADDR_W-1:2] : '0;
    assign bus.mem_we    = (dm_gnt && bus.dm_we) ? bus.dm_be : '0;
    assign bus.mem_wdata = rst ? '0 : bus.dm_wdata;

    // A read granted just before reset must not surface while rst is high.
    assign if_rvalid     = !rst && (rd_owner_q == OWN_IF);
    assign dm_rvalid     = !rst && (rd_owner_q == OWN_DM);
    assign bus.if_rvalid = if_rvalid;
    assign bus.dm_rvalid = dm_rvalid;
    assign bus.if_rdata  = if_rvalid ? bus.mem_rdata : '0;
    assign bus.dm_rdata  = dm_rvalid ? bus.mem_rdata : '0;

    assign bus.conflict_cnt   = rst ? 16'd0 : conflict_cnt_q;
    assign bus.dbg_rd_owner   = rd_owner_q;
    assign bus.dbg_starve_cnt = starve_cnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised and directed checks of mem_port_arbiter against a behavioural
// model of the arbitration rules and a shadow copy of the unified memory.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int ADDR_W     = 16;
  localparam int MAX_STARVE = 4;
  localparam int NWORDS     = 1 << (ADDR_W - 2);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .MAX_STARVE(MAX_STARVE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- memory attached to the DUT ----------------
  logic [31:0] mem_arr [NWORDS];
  logic [31:0] ref_mem [NWORDS];
  logic [31:0] mem_rdata_q = 32'h0;
  assign bus.mem_rdata = mem_rdata_q;

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we != 4'b0000) begin
        for (int b = 0; b < 4; b++)
          if (bus.mem_we[b]) mem_arr[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      end else begin
        mem_rdata_q <= mem_arr[bus.mem_addr];
      end
    end
  end

  // ---------------- scoreboard / reference model ----------------
  int n_vec = 0;
  int n_err = 0;

  int m_starve   = 0;   // consecutive cycles IF was denied
  int m_conflict = 0;   // cycles with both requesting, saturating
  int pend_own   = 0;   // 0 none, 1 IF, 2 DM : who gets data next cycle
  logic [31:0] pend_data = 32'h0;

  bit e_if, e_dm;
  logic [ADDR_W-3:0] e_addr;
  logic [3:0]  e_we;
  logic [31:0] e_cand;

  function automatic logic [ADDR_W-3:0] word_of(input logic [ADDR_W-1:0] a);
    return (ADDR_W-2)'(a / 4);
  endfunction

  function automatic void model_eval();
    e_if = 1'b0;
    e_dm = 1'b0;
    if (!rst) begin
      if (bus.if_req && bus.dm_req) begin
        if (m_starve >= MAX_STARVE) e_if = 1'b1;
        else                        e_dm = 1'b1;
      end else if (bus.if_req) e_if = 1'b1;
      else if (bus.dm_req)     e_dm = 1'b1;
    end
    e_addr = e_if ? word_of(bus.if_addr) : (e_dm ? word_of(bus.dm_addr) : '0);
    e_we   = (e_dm && bus.dm_we) ? bus.dm_be : 4'b0000;
    e_cand = ref_mem[e_addr];
  endfunction

  function automatic void model_update();
    if (rst) begin
      m_starve = 0; m_conflict = 0; pend_own = 0; pend_data = 32'h0;
    end else begin
      if (bus.if_req && bus.dm_req && m_conflict < 65535) m_conflict++;
      if (bus.if_req && !e_if) m_starve = (m_starve < MAX_STARVE) ? m_starve + 1 : MAX_STARVE;
      else                     m_starve = 0;
      pend_own  = e_if ? 1 : ((e_dm && !bus.dm_we) ? 2 : 0);
      pend_data = e_cand;
      if (e_dm && bus.dm_we)
        for (int b = 0; b < 4; b++)
          if (bus.dm_be[b]) ref_mem[e_addr][8*b +: 8] = bus.dm_wdata[8*b +: 8];
    end
  endfunction

  // ---------------- driver tasks ----------------
  // Every cycle: inputs set just after negedge, settle() evaluates the model,
  // finish_cycle() advances through the posedge and returns at the next negedge.
  task automatic set_idle();
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_be = 4'h0;
    bus.dm_addr = '0;  bus.dm_wdata = 32'h0;
  endtask

  task automatic settle();
    #1;
    model_eval();
  endtask

  task automatic finish_cycle();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_idle();
    settle();
    finish_cycle();
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      bus.if_req = 1'($urandom_range(0, 1));
      bus.dm_req = 1'($urandom_range(0, 1));
      bus.if_addr = 16'($urandom_range(0, 255));
      bus.dm_addr = 16'($urandom_range(0, 255));
      settle();
      n_vec++; if (bus.if_gnt !== 1'b0 || bus.dm_gnt !== 1'b0) begin n_err++;
        $display("FAIL reset_gnt c=%0d got if=%b dm=%b exp 0 0", c, bus.if_gnt, bus.dm_gnt); end
      n_vec++; if (bus.mem_en !== 1'b0) begin n_err++;
        $display("FAIL reset_mem_en c=%0d got=%b exp=0", c, bus.mem_en); end
      n_vec++; if (bus.if_rvalid !== 1'b0 || bus.dm_rvalid !== 1'b0) begin n_err++;
        $display("FAIL reset_rvalid c=%0d got if=%b dm=%b exp 0 0", c, bus.if_rvalid, bus.dm_rvalid); end
      n_vec++; if (bus.conflict_cnt !== 16'h0) begin n_err++;
        $display("FAIL reset_conflict c=%0d got=%h exp=0", c, bus.conflict_cnt); end
      finish_cycle();
    end
    rst = 1'b0;
    set_idle();
    settle();
    n_vec++; if (bus.dbg_rd_owner !== OWN_NONE) begin n_err++;
      $display("FAIL reset_owner got=%0d exp=%0d", bus.dbg_rd_owner, OWN_NONE); end
    finish_cycle();
  endtask

  task automatic test_if_fetch();
    set_idle();
    bus.if_req = 1'b1; bus.if_addr = 16'h0010;
    settle();
    n_vec++; if (bus.if_gnt !== 1'b1 || bus.dm_gnt !== 1'b0) begin n_err++;
      $display("FAIL fetch_gnt got if=%b dm=%b exp 1 0", bus.if_gnt, bus.dm_gnt); end
    n_vec++; if (bus.mem_addr !== 14'd4 || bus.mem_en !== 1'b1) begin n_err++;
      $display("FAIL fetch_mem got addr=%0d en=%b exp 4 1", bus.mem_addr, bus.mem_en); end
    finish_cycle();
    set_idle();
    settle();
    n_vec++; if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== 32'h00500093) begin n_err++;
      $display("FAIL fetch_rdata got v=%b d=%h exp 1 00500093", bus.if_rvalid, bus.if_rdata); end
    finish_cycle();
  endtask

  task automatic test_dm_write_read();
    set_idle();
    bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_be = 4'b0011;
    bus.dm_addr = 16'h0020; bus.dm_wdata = 32'hDEADBEEF;
    settle();
    n_vec++; if (bus.dm_gnt !== 1'b1 || bus.mem_we !== 4'b0011) begin n_err++;
      $display("FAIL wr_gnt got gnt=%b we=%b exp 1 0011", bus.dm_gnt, bus.mem_we); end
    n_vec++; if (bus.mem_addr !== 14'd8 || bus.mem_wdata !== 32'hDEADBEEF) begin n_err++;
      $display("FAIL wr_mem got addr=%0d wdata=%h exp 8 deadbeef", bus.mem_addr, bus.mem_wdata); end
    finish_cycle();
    bus.dm_we = 1'b0; bus.dm_be = 4'b0000;
    settle();
    n_vec++; if (bus.dm_rvalid !== 1'b0 || bus.if_rvalid !== 1'b0) begin n_err++;
      $display("FAIL wr_no_resp got dm=%b if=%b exp 0 0", bus.dm_rvalid, bus.if_rvalid); end
    n_vec++; if (bus.dm_gnt !== 1'b1 || bus.mem_we !== 4'b0000) begin n_err++;
      $display("FAIL rd_gnt got gnt=%b we=%b exp 1 0000", bus.dm_gnt, bus.mem_we); end
    finish_cycle();
    set_idle();
    settle();
    n_vec++; if (bus.dm_rvalid !== 1'b1 || bus.dm_rdata !== 32'h0000BEEF) begin n_err++;
      $display("FAIL rd_data got v=%b d=%h exp 1 0000beef", bus.dm_rvalid, bus.dm_rdata); end
    finish_cycle();
  endtask

  task automatic test_starvation();
    bit exp_if;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      bus.if_req = 1'b1; bus.if_addr = 16'($urandom_range(0, 255) * 4);
      bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 16'($urandom_range(0, 255) * 4);
      settle();
      exp_if = (c % (MAX_STARVE + 1)) == MAX_STARVE;
      n_vec++; if (bus.if_gnt !== exp_if || bus.dm_gnt !== !exp_if) begin n_err++;
        $display("FAIL starve_pattern c=%0d got if=%b dm=%b exp %b %b", c, bus.if_gnt, bus.dm_gnt, exp_if, !exp_if); end
      finish_cycle();
    end
    set_idle();
    settle();
    n_vec++; if (bus.conflict_cnt !== 16'd10) begin n_err++;
      $display("FAIL starve_conflict got=%0d exp=10", bus.conflict_cnt); end
    finish_cycle();
  endtask

  task automatic test_reset_mid_read();
    set_idle();
    bus.dm_req = 1'b1; bus.dm_addr = 16'($urandom_range(0, 255) * 4);
    settle();
    n_vec++; if (bus.dm_gnt !== 1'b1) begin n_err++;
      $display("FAIL rstrd_gnt got=%b exp=1", bus.dm_gnt); end
    finish_cycle();
    rst = 1'b1;
    set_idle();
    bus.if_req = 1'b1; bus.if_addr = 16'h0040;
    settle();
    n_vec++; if (bus.dm_rvalid !== 1'b0 || bus.dm_rdata !== 32'h0) begin n_err++;
      $display("FAIL rstrd_rvalid got v=%b d=%h exp 0 0", bus.dm_rvalid, bus.dm_rdata); end
    n_vec++; if (bus.if_gnt !== 1'b0 || bus.dm_gnt !== 1'b0 || bus.mem_en !== 1'b0) begin n_err++;
      $display("FAIL rstrd_gnt_in_reset got if=%b dm=%b en=%b exp 0 0 0", bus.if_gnt, bus.dm_gnt, bus.mem_en); end
    n_vec++; if (bus.mem_we !== 4'h0 || bus.mem_addr !== 14'h0 || bus.if_rdata !== 32'h0) begin n_err++;
      $display("FAIL rstrd_outs got we=%b addr=%h ird=%h exp 0 0 0", bus.mem_we, bus.mem_addr, bus.if_rdata); end
    finish_cycle();
    rst = 1'b0;
    settle();
    n_vec++; if (bus.if_gnt !== 1'b1 || bus.dm_rvalid !== 1'b0) begin n_err++;
      $display("FAIL rstrd_after got ifgnt=%b dmv=%b exp 1 0", bus.if_gnt, bus.dm_rvalid); end
    finish_cycle();
    set_idle();
    settle();
    n_vec++; if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== ref_mem[16]) begin n_err++;
      $display("FAIL rstrd_ifdata got v=%b d=%h exp 1 %h", bus.if_rvalid, bus.if_rdata, ref_mem[16]); end
    finish_cycle();
  endtask

  task automatic test_alternate();
    logic [31:0] prev_data;
    bit prev_is_if;
    logic [ADDR_W-1:0] a;
    prev_data = 32'h0;
    prev_is_if = 1'b0;
    for (int c = 0; c < 20; c++) begin
      set_idle();
      a = 16'($urandom_range(0, 63));
      if (c % 2 == 0) begin bus.if_req = 1'b1; bus.if_addr = a; end
      else            begin bus.dm_req = 1'b1; bus.dm_addr = a; end
      settle();
      n_vec++; if (bus.if_gnt !== (c % 2 == 0) || bus.dm_gnt !== (c % 2 == 1)) begin n_err++;
        $display("FAIL alt_gnt c=%0d got if=%b dm=%b", c, bus.if_gnt, bus.dm_gnt); end
      if (c > 0) begin
        n_vec++; if (bus.if_rvalid !== prev_is_if || bus.dm_rvalid !== !prev_is_if) begin n_err++;
          $display("FAIL alt_rvalid c=%0d got if=%b dm=%b exp %b %b", c, bus.if_rvalid, bus.dm_rvalid, prev_is_if, !prev_is_if); end
        n_vec++; if ((prev_is_if ? bus.if_rdata : bus.dm_rdata) !== prev_data
                     || (prev_is_if ? bus.dm_rdata : bus.if_rdata) !== 32'h0) begin n_err++;
          $display("FAIL alt_rdata c=%0d got if=%h dm=%h exp owner data %h", c, bus.if_rdata, bus.dm_rdata, prev_data); end
      end
      prev_data  = ref_mem[a / 4];
      prev_is_if = (c % 2 == 0);
      finish_cycle();
    end
  endtask

  task automatic test_random();
    bit xv_if, xv_dm;
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 39) == 0);
      bus.if_req   = 1'($urandom_range(0, 1));
      bus.if_addr  = 16'($urandom_range(0, 63));
      bus.dm_req   = 1'($urandom_range(0, 1));
      bus.dm_we    = 1'($urandom_range(0, 1));
      bus.dm_be    = 4'($urandom_range(0, 15));
      bus.dm_addr  = 16'($urandom_range(0, 63));
      bus.dm_wdata = $urandom;
      settle();
      xv_if = !rst && pend_own == 1;
      xv_dm = !rst && pend_own == 2;
      n_vec++; if (bus.if_gnt !== e_if || bus.dm_gnt !== e_dm) begin n_err++;
        $display("FAIL rnd_gnt c=%0d got if=%b dm=%b exp %b %b", c, bus.if_gnt, bus.dm_gnt, e_if, e_dm); end
      n_vec++; if (bus.mem_en !== (e_if || e_dm) || bus.mem_we !== e_we) begin n_err++;
        $display("FAIL rnd_mem_ctl c=%0d got en=%b we=%b exp %b %b", c, bus.mem_en, bus.mem_we, e_if || e_dm, e_we); end
      if (e_if || e_dm) begin
        n_vec++; if (bus.mem_addr !== e_addr) begin n_err++;
          $display("FAIL rnd_mem_addr c=%0d got=%h exp=%h", c, bus.mem_addr, e_addr); end
      end
      if (e_we != 4'b0000) begin
        n_vec++; if (bus.mem_wdata !== bus.dm_wdata) begin n_err++;
          $display("FAIL rnd_wdata c=%0d got=%h exp=%h", c, bus.mem_wdata, bus.dm_wdata); end
      end
      n_vec++; if (bus.if_rvalid !== xv_if || bus.if_rdata !== (xv_if ? pend_data : 32'h0)) begin n_err++;
        $display("FAIL rnd_if_resp c=%0d got v=%b d=%h exp %b %h", c, bus.if_rvalid, bus.if_rdata, xv_if, xv_if ? pend_data : 32'h0); end
      n_vec++; if (bus.dm_rvalid !== xv_dm || bus.dm_rdata !== (xv_dm ? pend_data : 32'h0)) begin n_err++;
        $display("FAIL rnd_dm_resp c=%0d got v=%b d=%h exp %b %h", c, bus.dm_rvalid, bus.dm_rdata, xv_dm, xv_dm ? pend_data : 32'h0); end
      n_vec++; if (bus.conflict_cnt !== 16'(rst ? 0 : m_conflict)) begin n_err++;
        $display("FAIL rnd_conflict c=%0d got=%0d exp=%0d", c, bus.conflict_cnt, rst ? 0 : m_conflict); end
      finish_cycle();
    end
    rst = 1'b0;
  endtask

  task automatic test_saturation();
    int dut_if_n;
    int mod_if_n;
    dut_if_n = 0;
    mod_if_n = 0;
    do_reset();
    set_idle();
    bus.if_req = 1'b1; bus.if_addr = 16'h0008;
    bus.dm_req = 1'b1; bus.dm_addr = 16'h000C;
    settle();
    repeat (70000) begin
      @(posedge clk);
      model_update();
      #1;
      model_eval();
      if (bus.if_gnt === 1'b1) dut_if_n++;
      if (e_if) mod_if_n++;
    end
    @(negedge clk);
    set_idle();
    settle();
    n_vec++; if (bus.conflict_cnt !== 16'hFFFF) begin n_err++;
      $display("FAIL sat_conflict got=%h exp=ffff", bus.conflict_cnt); end
    n_vec++; if (dut_if_n != mod_if_n) begin n_err++;
      $display("FAIL sat_if_share got=%0d exp=%0d", dut_if_n, mod_if_n); end
    finish_cycle();
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    logic [31:0] v;
    for (int i = 0; i < NWORDS; i++) begin
      v = $urandom;
      mem_arr[i] = v;
      ref_mem[i] = v;
    end
    mem_arr[4] = 32'h00500093; ref_mem[4] = 32'h00500093;
    mem_arr[8] = 32'h0;        ref_mem[8] = 32'h0;
    set_idle();
    @(negedge clk);
    test_reset();
    test_if_fetch();
    test_dm_write_read();
    test_starvation();
    test_reset_mid_read();
    test_alternate();
    test_random();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
